// File: rtl/dmem_arbiter_ctrl.sv
// Purpose : shares the single-port word RAM between the CPU load/store unit and a DMA/debug
//           port (round-robin), turning byte/half/word loads and stores into word accesses.
// Latency : accept at N -> load/word store rsp N+2, sub-word store (RMW) N+3, error N+1.
// Backpressure: one request in flight; req_ready only in IDLE; responses cannot be stalled.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   {cpu,dma}_req_*          valid/ready request: we, size (00 B, 01 H, 10 W, 11 illegal),
//                            unsigned (zero-extend loads), byte addr, right-aligned wdata
//   {cpu,dma}_rsp_*          one-cycle response pulse with rdata (loads only) and err
//   ram_we/ram_addr/ram_din  word RAM write enable, word-aligned byte address, write data
//   ram_dout                 RAM read data, combinational from ram_addr
//   stat_*                   grant/conflict counters, present only with DMEM_STATS_EN defined
//
// Optional feature macro: DMEM_STATS_EN
module dmem_arbiter_ctrl #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_req_we,
  input  logic [1:0]  cpu_req_size,
  input  logic        cpu_req_unsigned,
  input  logic [31:0] cpu_req_addr,
  input  logic [31:0] cpu_req_wdata,
  output logic        cpu_rsp_valid,
  output logic [31:0] cpu_rsp_rdata,
  output logic        cpu_rsp_err,
  input  logic        dma_req_valid,
  output logic        dma_req_ready,
  input  logic        dma_req_we,
  input  logic [1:0]  dma_req_size,
  input  logic        dma_req_unsigned,
  input  logic [31:0] dma_req_addr,
  input  logic [31:0] dma_req_wdata,
  output logic        dma_rsp_valid,
  output logic [31:0] dma_rsp_rdata,
  output logic        dma_rsp_err,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] stat_cpu_grants,
  output logic [31:0] stat_dma_grants,
  output logic [31:0] stat_conflicts
`endif
);

  // Latched request, same layout for both ports.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RMW_WR = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [1:0]  state_q;
  logic        last_grant_q;
  logic        port_q;
  req_t        req_q;
  logic        err_q;
  logic [31:0] old_q;     // word read in ACCESS, merged with store data in RMW_WR
  logic [31:0] rdata_q;   // cleared at grant so stores and errors answer with 0

  logic        grant_vld;
  logic        grant_port;
  req_t        grant_req;
  logic        grant_bad;
  logic        rsp_vld;

  // Misaligned, out-of-range or illegal-size requests never touch the RAM.
  function automatic logic req_bad(input req_t r);
    logic bad;
    bad = (r.size == SZ_ILL)
       || ((r.size == SZ_HALF) && r.addr[0])
       || ((r.size == SZ_WORD) && (r.addr[1:0] != 2'b00))
       || ({2'b00, r.addr[31:2]} >= DEPTH_W);
    return bad;
  endfunction

  // Little-endian lane select followed by sign/zero extension.
  function automatic logic [31:0] load_extract(input req_t r, input logic [31:0] word);
    logic [31:0] lane;
    logic [31:0] v;
    lane = word >> {r.addr[1:0], 3'b000};
    case (r.size)
      SZ_BYTE: v = {{24{~r.uns & lane[7]}}, lane[7:0]};
      SZ_HALF: v = {{16{~r.uns & lane[15]}}, lane[15:0]};
      default: v = word;
    endcase
    return v;
  endfunction

  // Replace the addressed byte or halfword of the old word with the store data.
  function automatic logic [31:0] store_merge(input req_t r, input logic [31:0] old);
    logic [31:0] mask;
    logic [31:0] data;
    if (r.size == SZ_BYTE) begin
      mask = 32'h0000_00FF << {r.addr[1:0], 3'b000};
      data = {24'd0, r.wdata[7:0]} << {r.addr[1:0], 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {r.addr[1:0], 3'b000};
      data = {16'd0, r.wdata[15:0]} << {r.addr[1:0], 3'b000};
    end
    return (old & ~mask) | (data & mask);
  endfunction

  // Round-robin: a lone requester always wins; on a tie the port that did not win last time goes.
  always_comb begin
    grant_vld = (state_q == S_IDLE) && !rst && (cpu_req_valid || dma_req_valid);
    if (cpu_req_valid && dma_req_valid) begin
      grant_port = ~last_grant_q;
    end else begin
      grant_port = dma_req_valid ? PORT_DMA : PORT_CPU;
    end
  end

  assign cpu_req_ready = grant_vld && (grant_port == PORT_CPU);
  assign dma_req_ready = grant_vld && (grant_port == PORT_DMA);

  assign grant_req = (grant_port == PORT_DMA)
                   ? {dma_req_we, dma_req_size, dma_req_unsigned, dma_req_addr, dma_req_wdata}
                   : {cpu_req_we, cpu_req_size, cpu_req_unsigned, cpu_req_addr, cpu_req_wdata};
  assign grant_bad = req_bad(grant_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= PORT_DMA;
      port_q       <= PORT_CPU;
      req_q        <= '0;
      err_q        <= 1'b0;
      old_q        <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            port_q       <= grant_port;
            last_grant_q <= grant_port;
            req_q        <= grant_req;
            err_q        <= grant_bad;
            rdata_q      <= '0;
            state_q      <= grant_bad ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!req_q.we) begin
            rdata_q <= load_extract(req_q, ram_dout);
            state_q <= S_RESP;
          end else if (req_q.size == SZ_WORD) begin
            state_q <= S_RESP;
          end else begin
            old_q   <= ram_dout;
            state_q <= S_RMW_WR;
          end
        end
        S_RMW_WR: begin
          state_q <= S_RESP;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // RAM side is driven purely from state; everything is forced low while rst is high so an
  // RMW interrupted by reset never completes its write.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (!rst) begin
      case (state_q)
        S_ACCESS: begin
          ram_addr = {req_q.addr[31:2], 2'b00};
          if (req_q.we && (req_q.size == SZ_WORD)) begin
            ram_we  = 1'b1;
            ram_din = req_q.wdata;
          end
        end
        S_RMW_WR: begin
          ram_addr = {req_q.addr[31:2], 2'b00};
          ram_we   = 1'b1;
          ram_din  = store_merge(req_q, old_q);
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_vld = !rst && (state_q == S_RESP);

  assign cpu_rsp_valid = rsp_vld && (port_q == PORT_CPU);
  assign cpu_rsp_rdata = cpu_rsp_valid ? rdata_q : '0;
  assign cpu_rsp_err   = cpu_rsp_valid && err_q;
  assign dma_rsp_valid = rsp_vld && (port_q == PORT_DMA);
  assign dma_rsp_rdata = dma_rsp_valid ? rdata_q : '0;
  assign dma_rsp_err   = dma_rsp_valid && err_q;

`ifdef DMEM_STATS_EN
  // Free-running 32-bit counters; wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cpu_grants <= '0;
      stat_dma_grants <= '0;
      stat_conflicts  <= '0;
    end else begin
      if (cpu_req_ready) begin
        stat_cpu_grants <= stat_cpu_grants + 32'd1;
      end
      if (dma_req_ready) begin
        stat_dma_grants <= stat_dma_grants + 32'd1;
      end
      if ((state_q == S_IDLE) && cpu_req_valid && dma_req_valid) begin
        stat_conflicts <= stat_conflicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// Purpose : self-checking bench for dmem_arbiter_ctrl with a behavioural word RAM.
// Latency : n/a (bench).
// Backpressure: requests held until ready; each wait is bounded by a cycle budget.
module tb_dmem_arbiter_ctrl;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we, cpu_req_unsigned;
  logic [1:0]  cpu_req_size;
  logic [31:0] cpu_req_addr, cpu_req_wdata;
  logic        cpu_rsp_valid, cpu_rsp_err;
  logic [31:0] cpu_rsp_rdata;
  logic        dma_req_valid, dma_req_ready, dma_req_we, dma_req_unsigned;
  logic [1:0]  dma_req_size;
  logic [31:0] dma_req_addr, dma_req_wdata;
  logic        dma_rsp_valid, dma_rsp_err;
  logic [31:0] dma_rsp_rdata;
  logic        ram_we;
  logic [31:0] ram_addr, ram_din, ram_dout;
`ifdef DMEM_STATS_EN
  logic [31:0] stat_cpu_grants, stat_dma_grants, stat_conflicts;
`endif

  dmem_arbiter_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_size(cpu_req_size), .cpu_req_unsigned(cpu_req_unsigned),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_we(dma_req_we),
    .dma_req_size(dma_req_size), .dma_req_unsigned(dma_req_unsigned),
    .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata), .dma_rsp_err(dma_rsp_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef DMEM_STATS_EN
    , .stat_cpu_grants(stat_cpu_grants), .stat_dma_grants(stat_dma_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, write on rising edge.
  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [7:0]  ram_idx;
  int          we_cnt;

  assign ram_idx  = ram_addr[9:2];
  assign ram_dout = mem[ram_idx];

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] = ram_din;
      we_cnt = we_cnt + 1;
    end
  end

  int n_cmp;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit port, input bit v, input bit we, input logic [1:0] size,
                       input bit uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      dma_req_valid = v; dma_req_we = we; dma_req_size = size;
      dma_req_unsigned = uns; dma_req_addr = addr; dma_req_wdata = wdata;
    end else begin
      cpu_req_valid = v; cpu_req_we = we; cpu_req_size = size;
      cpu_req_unsigned = uns; cpu_req_addr = addr; cpu_req_wdata = wdata;
    end
  endtask

  // Reference model: byte-addressed little-endian memory semantics expressed with arithmetic.
  task automatic model(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output bit err, output int lat);
    int unsigned nbytes, idx, sh;
    logic [31:0] mask, v;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err    = (size == 2'd3) || ((addr % nbytes) != 0) || ((addr / 4) >= DEPTH);
    rd     = 32'd0;
    lat    = 1;
    if (!err) begin
      idx  = addr / 4;
      sh   = (addr % 4) * 8;
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      if (we) begin
        ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wdata & mask) << sh);
        lat = (nbytes == 4) ? 2 : 3;
      end else begin
        v = (ref_mem[idx] >> sh) & mask;
        if (!uns && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
        rd  = v;
        lat = 2;
      end
    end
  endtask

  // One complete transaction on one port, checking acceptance, latency, data and pulse shape.
  task automatic do_req(input bit port, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input bit exp_err, input int exp_lat,
                        input string name);
    bit got;
    int lat, we0;
    logic [31:0] rd;
    logic er, oth, after;
    @(posedge clk); #1;
    drive(port, 1'b1, we, size, uns, addr, wdata);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = port ? dma_req_ready : cpu_req_ready;
    end
    chk({name, "/accept"}, 32'(got), 32'd1);
    @(posedge clk); #1;
    we0 = we_cnt;
    drive(port, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    if (got) begin
      lat = 0; rd = '0; er = 1'b0; oth = 1'b0;
      for (int k = 1; k <= 6 && lat == 0; k++) begin
        @(negedge clk);
        if (port ? dma_rsp_valid : cpu_rsp_valid) begin
          lat = k;
          rd  = port ? dma_rsp_rdata : cpu_rsp_rdata;
          er  = port ? dma_rsp_err : cpu_rsp_err;
          oth = port ? cpu_rsp_valid : dma_rsp_valid;
        end
      end
      chk({name, "/latency"}, 32'(lat), 32'(exp_lat));
      chk({name, "/rdata"}, rd, exp_rd);
      chk({name, "/err"}, 32'(er), 32'(exp_err));
      chk({name, "/other_rsp"}, 32'(oth), 32'd0);
      @(negedge clk);
      after = port ? dma_rsp_valid : cpu_rsp_valid;
      chk({name, "/pulse_one_cycle"}, 32'(after), 32'd0);
      if (exp_err) chk({name, "/no_ram_we"}, 32'(we_cnt - we0), 32'd0);
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          lat;
    string       name;
  } vec_t;

  function automatic vec_t mk(input bit port, input bit we, input logic [1:0] size, input bit uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input bit exp_err, input int lat,
                              input string name);
    vec_t v;
    v.port = port; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.lat = lat; v.name = name;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    bit grants [4];
    bit exp_order [4];
    int ngrant, both_rdy, bad, pulses;
    logic [31:0] m_rd;
    bit m_err;
    int m_lat;
    bit rp, rwe, runs;
    logic [1:0] rsz;
    logic [31:0] raddr, rwdata;

    n_cmp = 0; n_fail = 0; we_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 32'd0; ref_mem[i] = 32'd0;
    end
    mem[25]  = 32'hDEAD_BEEF; ref_mem[25]  = 32'hDEAD_BEEF;
    mem[255] = 32'h1234_5678; ref_mem[255] = 32'h1234_5678;

    //          port we  size  uns addr       wdata         exp_rd        err lat name
    tbl[0]  = mk(0, 0, 2'd2, 0, 32'h64,  32'h0,        32'hDEAD_BEEF, 0, 2, "lw_64");
    tbl[1]  = mk(0, 0, 2'd0, 0, 32'h67,  32'h0,        32'hFFFF_FFDE, 0, 2, "lb_67");
    tbl[2]  = mk(0, 0, 2'd0, 1, 32'h67,  32'h0,        32'h0000_00DE, 0, 2, "lbu_67");
    tbl[3]  = mk(0, 0, 2'd1, 0, 32'h66,  32'h0,        32'hFFFF_DEAD, 0, 2, "lh_66");
    tbl[4]  = mk(1, 0, 2'd1, 1, 32'h64,  32'h0,        32'h0000_BEEF, 0, 2, "lhu_64_dma");
    tbl[5]  = mk(0, 1, 2'd2, 0, 32'h28,  32'hCAFE_BABE, 32'h0,        0, 2, "sw_28");
    tbl[6]  = mk(1, 1, 2'd0, 0, 32'h28,  32'h0000_00AA, 32'h0,        0, 3, "sb_28_dma");
    tbl[7]  = mk(0, 0, 2'd2, 0, 32'h28,  32'h0,        32'hCAFE_BAAA, 0, 2, "lw_28_after_sb");
    tbl[8]  = mk(1, 1, 2'd1, 0, 32'h2A,  32'hFFFF_1234, 32'h0,        0, 3, "sh_2a_dma");
    tbl[9]  = mk(0, 0, 2'd2, 0, 32'h28,  32'h0,        32'h1234_BAAA, 0, 2, "lw_28_after_sh");
    tbl[10] = mk(1, 0, 2'd0, 0, 32'h2B,  32'h0,        32'h0000_0012, 0, 2, "lb_2b_dma");
    tbl[11] = mk(1, 0, 2'd1, 0, 32'h2A,  32'h0,        32'h0000_1234, 0, 2, "lh_2a_dma");
    tbl[12] = mk(0, 0, 2'd2, 0, 32'h2A,  32'h0,        32'h0,         1, 1, "lw_misaligned");
    tbl[13] = mk(0, 1, 2'd1, 0, 32'h29,  32'h5555,     32'h0,         1, 1, "sh_misaligned");
    tbl[14] = mk(0, 0, 2'd2, 0, 32'h400, 32'h0,        32'h0,         1, 1, "lw_out_of_range");
    tbl[15] = mk(1, 1, 2'd3, 0, 32'h20,  32'h7777,     32'h0,         1, 1, "illegal_size");

    // Reset with both ports already requesting.
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h64, 32'd0);
    drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h28, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst/req_ready", {30'd0, cpu_req_ready, dma_req_ready}, 32'd0);
    chk("rst/ram_we", 32'(ram_we), 32'd0);
    chk("rst/ram_addr", ram_addr, 32'd0);
    chk("rst/ram_din", ram_din, 32'd0);
    chk("rst/rsp_flags", {28'd0, cpu_rsp_valid, dma_rsp_valid, cpu_rsp_err, dma_rsp_err}, 32'd0);
    chk("rst/rsp_rdata", cpu_rsp_rdata | dma_rsp_rdata, 32'd0);

    // Held simultaneous requests: cpu first after reset, then strict alternation.
    @(posedge clk); #1;
    rst = 1'b0;
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
    ngrant = 0; both_rdy = 0;
    for (int c = 0; c < 60 && ngrant < 4; c++) begin
      @(negedge clk);
      if (cpu_req_ready && dma_req_ready) both_rdy++;
      if (cpu_req_ready) begin
        grants[ngrant] = 1'b0; ngrant++;
      end else if (dma_req_ready) begin
        grants[ngrant] = 1'b1; ngrant++;
      end
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    chk("arb/grant_count", 32'(ngrant), 32'd4);
    chk("arb/both_ready", 32'(both_rdy), 32'd0);
    for (int g = 0; g < 4; g++) chk($sformatf("arb/grant%0d_port", g), 32'(grants[g]), 32'(exp_order[g]));
    repeat (6) @(posedge clk);
`ifdef DMEM_STATS_EN
    chk("stats/cpu_grants", stat_cpu_grants, 32'd2);
    chk("stats/dma_grants", stat_dma_grants, 32'd2);
    chk("stats/conflicts", stat_conflicts, 32'd4);
`endif

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, m_rd, m_err, m_lat);
      do_req(tbl[i].port, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
             tbl[i].exp_rd, tbl[i].exp_err, tbl[i].lat, tbl[i].name);
    end

    // Reset arriving during the write half of a byte RMW to the last word.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h3FC, 32'h0000_0055);
    ngrant = 0;
    for (int k = 0; k < 20 && ngrant == 0; k++) begin
      @(negedge clk);
      if (cpu_req_ready) ngrant = 1;
    end
    chk("rmw_rst/accept", 32'(ngrant), 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rmw_rst/ram_we_gated", 32'(ram_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rmw_rst/outputs_after", {27'd0, cpu_req_ready, dma_req_ready, ram_we,
        cpu_rsp_valid, dma_rsp_valid}, 32'd0);
    chk("rmw_rst/ram_addr_after", ram_addr | ram_din | cpu_rsp_rdata | dma_rsp_rdata, 32'd0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cpu_rsp_valid || dma_rsp_valid) pulses++;
    end
    chk("rmw_rst/no_rsp", 32'(pulses), 32'd0);
    chk("rmw_rst/mem255", mem[255], 32'h1234_5678);
    do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0, 32'h1234_5678, 1'b0, 2, "lw_3fc_after_rst");

    // Random traffic against the reference model.
    for (int i = 0; i < 200; i++) begin
      rp   = 1'($urandom_range(0, 1));
      rwe  = 1'($urandom_range(0, 1));
      runs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1, 2: rsz = 2'd0;
        3, 4, 5: rsz = 2'd1;
        6, 7, 8: rsz = 2'd2;
        default: rsz = 2'd3;
      endcase
      if ($urandom_range(0, 9) == 0) raddr = 32'h3F0 + 32'($urandom_range(0, 31));
      else                           raddr = 32'($urandom_range(0, 63));
      rwdata = $urandom;
      model(rwe, rsz, runs, raddr, rwdata, m_rd, m_err, m_lat);
      do_req(rp, rwe, rsz, runs, raddr, rwdata, m_rd, m_err, m_lat, $sformatf("rnd%0d", i));
    end

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("final_mem_words_differing", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
